// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;

    localparam int IF_ADDR_W = 16;
    localparam int IF_INSTR_W = 16;
    localparam int PC_INC = 2;
    localparam logic [IF_INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [IF_INSTR_W-1:0] instr;
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_ADDR_W-1:0]  pc_plus;
        logic                  valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_reg_if_id.sv
// reg_if_id: IF/ID pipeline register with flush, hold, load and bubble controls
module reg_if_id #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               hold,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [ADDR_W-1:0]  pc_d,
    input  logic [ADDR_W-1:0]  pc_plus_d,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_plus,
    output logic               ifid_valid
);

    // flush kills the slot, hold freezes it, otherwise load a new instruction or insert a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid   <= 1'b0;
            ifid_instr   <= NOP_INSTR;
            ifid_pc      <= '0;
            ifid_pc_plus <= '0;
        end else if (flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
        end else if (!hold) begin
            ifid_valid <= load;
            ifid_instr <= load ? instr_d : NOP_INSTR;
            if (load) begin
                ifid_pc      <= pc_d;
                ifid_pc_plus <= pc_plus_d;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: issues instruction-memory requests, steers the PC and feeds the IF/ID register
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_W = fetch_pkg::IF_ADDR_W,
    parameter int INSTR_W = fetch_pkg::IF_INSTR_W,
    parameter int PC_INC = fetch_pkg::PC_INC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt_sys,
    input  logic               stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [ADDR_W-1:0]  pc_current,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               fetch_stall,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_plus,
    output logic               ifid_valid
);

    fetch_state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_seq;
    logic accept;

    assign pc_seq = pc_current + ADDR_W'(PC_INC);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // a request left outstanding by a redirect is drained in DISCARD so its data is never used
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:   state_d = (imem_req && !imem_ready) ? (flush ? DISCARD : WAIT) : FETCH;
            WAIT:    state_d = imem_ready ? FETCH : (flush ? DISCARD : WAIT);
            DISCARD: state_d = imem_ready ? FETCH : DISCARD;
            default: state_d = FETCH;
        endcase
    end

    // once issued, a request stays up until its response so the memory contract is never broken
    always_comb begin
        imem_req    = !rst && ((state_q == FETCH && !halt_sys) || state_q == WAIT);
        imem_addr   = pc_current;
        accept      = (state_q == FETCH || state_q == WAIT) && imem_req && imem_ready
                      && !flush && !halt_sys && !stall;
        fetch_stall = !(accept || flush);
        next_pc     = flush ? branch_target : pc_seq;
    end

    reg_if_id #(
        .ADDR_W(ADDR_W),
        .INSTR_W(INSTR_W),
        .NOP_INSTR(NOP_INSTR)
    ) u_reg_if_id (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .hold(halt_sys || stall),
        .load(accept),
        .instr_d(imem_data),
        .pc_d(pc_current),
        .pc_plus_d(pc_seq),
        .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc),
        .ifid_pc_plus(ifid_pc_plus),
        .ifid_valid(ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard-checked IF/ID stream
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_sys = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] branch_target = '0;
    logic [15:0] pc_current = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_data = '0;
    logic [15:0] next_pc;
    logic        fetch_stall;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus;
    logic        ifid_valid;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_plus;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    logic load_ok = 1'b0;

    fetch_stage dut (
        .clk(clk),
        .rst(rst),
        .halt_sys(halt_sys),
        .stall(stall),
        .flush(flush),
        .branch_target(branch_target),
        .pc_current(pc_current),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_data(imem_data),
        .next_pc(next_pc),
        .fetch_stall(fetch_stall),
        .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc),
        .ifid_pc_plus(ifid_pc_plus),
        .ifid_valid(ifid_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, h, s, f, input logic [15:0] bt, pc,
                        input logic rdy, input logic [15:0] d);
        @(negedge clk);
        rst = r;
        halt_sys = h;
        stall = s;
        flush = f;
        branch_target = bt;
        pc_current = pc;
        imem_ready = rdy;
        imem_data = d;
        #1;
    endtask

    task automatic push(input logic [15:0] i, p, pp);
        exp_t x;
        x.instr = i;
        x.pc = p;
        x.pc_plus = pp;
        sb.push_back(x);
    endtask

    // a new IF/ID entry can only appear after an edge with no reset, flush, halt or stall
    always @(posedge clk) load_ok = !(rst || flush || halt_sys || stall);

    always @(negedge clk) begin
        if (ifid_valid && load_ok) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_load: got instr %h pc %h expected none", ifid_instr, ifid_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_instr", {16'h0, ifid_instr}, {16'h0, e.instr});
                chk("sb_pc", {16'h0, ifid_pc}, {16'h0, e.pc});
                chk("sb_pc_plus", {16'h0, ifid_pc_plus}, {16'h0, e.pc_plus});
            end
        end
    end

    initial begin
        // reset
        step(1, 0, 0, 0, 16'h0, 16'h0000, 0, 16'h0);
        chk("rst_req", imem_req, 0);
        step(1, 0, 0, 0, 16'h0, 16'h0000, 0, 16'h0);
        chk("rst_req2", imem_req, 0);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_instr", ifid_instr, 16'h0000);
        chk("rst_pc", ifid_pc, 16'h0000);
        chk("rst_pc_plus", ifid_pc_plus, 16'h0000);
        // zero-wait stream
        step(0, 0, 0, 0, 16'h0, 16'h0000, 1, 16'h1111);
        chk("zw_req", imem_req, 1);
        chk("zw_addr", imem_addr, 16'h0000);
        chk("zw_stall0", fetch_stall, 0);
        chk("zw_next0", next_pc, 16'h0002);
        push(16'h1111, 16'h0000, 16'h0002);
        step(0, 0, 0, 0, 16'h0, 16'h0002, 1, 16'h2222);
        chk("zw_stall1", fetch_stall, 0);
        chk("zw_next1", next_pc, 16'h0004);
        push(16'h2222, 16'h0002, 16'h0004);
        step(0, 0, 0, 0, 16'h0, 16'h0004, 1, 16'h3333);
        chk("zw_stall2", fetch_stall, 0);
        chk("zw_next2", next_pc, 16'h0006);
        push(16'h3333, 16'h0004, 16'h0006);
        // three-cycle memory
        step(0, 0, 0, 0, 16'h0, 16'h0010, 0, 16'h0);
        chk("w3_req0", imem_req, 1);
        chk("w3_addr0", imem_addr, 16'h0010);
        chk("w3_stall0", fetch_stall, 1);
        step(0, 0, 0, 0, 16'h0, 16'h0010, 0, 16'h0);
        chk("w3_req1", imem_req, 1);
        chk("w3_addr1", imem_addr, 16'h0010);
        chk("w3_stall1", fetch_stall, 1);
        chk("w3_bubble", ifid_valid, 0);
        step(0, 0, 0, 0, 16'h0, 16'h0010, 1, 16'hAAAA);
        chk("w3_stall2", fetch_stall, 0);
        chk("w3_next", next_pc, 16'h0012);
        chk("w3_bubble2", ifid_valid, 0);
        push(16'hAAAA, 16'h0010, 16'h0012);
        // flush while waiting
        step(0, 0, 0, 0, 16'h0, 16'h0020, 0, 16'h0);
        chk("fw_req", imem_req, 1);
        step(0, 0, 0, 1, 16'h0100, 16'h0020, 0, 16'h0);
        chk("fw_next", next_pc, 16'h0100);
        chk("fw_stall", fetch_stall, 0);
        chk("fw_req_held", imem_req, 1);
        step(0, 0, 0, 0, 16'h0, 16'h0100, 0, 16'h0);
        chk("fw_discard_req", imem_req, 0);
        chk("fw_discard_stall", fetch_stall, 1);
        chk("fw_killed", ifid_valid, 0);
        step(0, 0, 0, 0, 16'h0, 16'h0100, 1, 16'hDEAD);
        chk("fw_stale_req", imem_req, 0);
        step(0, 0, 0, 0, 16'h0, 16'h0100, 1, 16'hBEEF);
        chk("fw_refetch_req", imem_req, 1);
        chk("fw_refetch_addr", imem_addr, 16'h0100);
        chk("fw_stale_dropped", ifid_valid, 0);
        push(16'hBEEF, 16'h0100, 16'h0102);
        // stall as data arrives
        step(0, 0, 1, 0, 16'h0, 16'h0102, 1, 16'h5555);
        chk("st_stall", fetch_stall, 1);
        chk("st_req", imem_req, 1);
        step(0, 0, 0, 0, 16'h0, 16'h0102, 1, 16'h5555);
        chk("st_hold_valid", ifid_valid, 1);
        chk("st_hold_instr", ifid_instr, 16'hBEEF);
        chk("st_hold_pc", ifid_pc, 16'h0100);
        chk("st_release", fetch_stall, 0);
        push(16'h5555, 16'h0102, 16'h0104);
        // halt in FETCH
        step(0, 1, 0, 0, 16'h0, 16'h0104, 0, 16'h0);
        chk("hf_req", imem_req, 0);
        chk("hf_stall", fetch_stall, 1);
        step(0, 1, 0, 0, 16'h0, 16'h0104, 0, 16'h0);
        chk("hf_req2", imem_req, 0);
        chk("hf_hold_valid", ifid_valid, 1);
        chk("hf_hold_instr", ifid_instr, 16'h5555);
        chk("hf_hold_pc", ifid_pc, 16'h0102);
        // halt in WAIT
        step(0, 0, 0, 0, 16'h0, 16'h0104, 0, 16'h0);
        chk("hw_req", imem_req, 1);
        chk("hw_hold_valid", ifid_valid, 1);
        step(0, 1, 0, 0, 16'h0, 16'h0104, 0, 16'h0);
        chk("hw_req_held", imem_req, 1);
        chk("hw_bubble", ifid_valid, 0);
        step(0, 1, 0, 0, 16'h0, 16'h0104, 1, 16'h7777);
        chk("hw_req_ready", imem_req, 1);
        chk("hw_drop_stall", fetch_stall, 1);
        step(0, 1, 0, 0, 16'h0, 16'h0104, 0, 16'h0);
        chk("hw_no_req", imem_req, 0);
        chk("hw_dropped", ifid_valid, 0);
        step(0, 0, 0, 0, 16'h0, 16'h0104, 1, 16'h8888);
        chk("hw_resume_req", imem_req, 1);
        chk("hw_resume_stall", fetch_stall, 0);
        push(16'h8888, 16'h0104, 16'h0106);
        // address wrap
        step(0, 0, 0, 0, 16'h0, 16'hFFFE, 1, 16'h9999);
        chk("wr_next", next_pc, 16'h0000);
        chk("wr_stall", fetch_stall, 0);
        push(16'h9999, 16'hFFFE, 16'h0000);
        step(0, 0, 0, 0, 16'h0, 16'h0000, 0, 16'h0);
        chk("wr_pc", ifid_pc, 16'hFFFE);
        chk("wr_pc_plus", ifid_pc_plus, 16'h0000);
        // reset while waiting
        step(1, 0, 0, 0, 16'h0, 16'h0000, 0, 16'h0);
        chk("rw_req", imem_req, 0);
        step(0, 1, 0, 0, 16'h0, 16'h0030, 0, 16'h0);
        chk("rw_fetch_state", imem_req, 0);
        chk("rw_valid", ifid_valid, 0);
        chk("rw_instr", ifid_instr, 16'h0000);
        // flush with a zero-wait response
        step(0, 0, 0, 1, 16'h0200, 16'h0030, 1, 16'h1234);
        chk("ff_req", imem_req, 1);
        chk("ff_stall", fetch_stall, 0);
        chk("ff_next", next_pc, 16'h0200);
        step(0, 0, 0, 0, 16'h0, 16'h0200, 1, 16'h4242);
        chk("ff_killed", ifid_valid, 0);
        chk("ff_addr", imem_addr, 16'h0200);
        push(16'h4242, 16'h0200, 16'h0202);
        step(0, 1, 0, 0, 16'h0, 16'h0202, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0, 16'h0202, 0, 16'h0);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage wrapped around the program counter register.
- Takes the current PC and issues a variable-latency instruction-memory request.
- Computes the next PC (sequential or branch target), drives the PC register's stall, and owns the IF/ID pipeline register consumed by decode.
- Handles hazard stalls, branch flushes, system halt, and discards in-flight responses after a redirect.

Parameters:
ADDR_W, 16, PC and memory address width
INSTR_W, 16, instruction width
PC_INC, 2, byte increment per sequential instruction
NOP_INSTR, 16'h0000, encoding inserted into IF/ID on bubble/flush/reset

Ports:
clk  in  1  system clock
rst  in  1  reset
halt_sys  in  1  main-control halt; freezes fetch
stall  in  1  hazard-unit stall; holds IF/ID
flush  in  1  taken branch/jump; redirect to branch_target, kill IF/ID
branch_target  in  ADDR_W  redirect address
pc_current  in  ADDR_W  current PC from program counter register
imem_req  out  1  instruction-memory request
imem_addr  out  ADDR_W  request address
imem_ready  in  1  one-cycle response strobe, imem_data valid
imem_data  in  INSTR_W  instruction returned
next_pc  out  ADDR_W  to PC register next-address input
fetch_stall  out  1  to PC register stall input
ifid_instr  out  INSTR_W  IF/ID instruction
ifid_pc  out  ADDR_W  IF/ID instruction address
ifid_pc_plus  out  ADDR_W  IF/ID pc + PC_INC
ifid_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset: one clock `clk`, reset `rst`, synchronous, active-high.
  - Reset values: state FETCH, ifid_valid 0, ifid_instr NOP_INSTR, ifid_pc 0, ifid_pc_plus 0.
  - imem_req is 0 during any reset cycle. Memory is reset by the same rst, so no response survives reset.
- Memory contract:
  - A request is launched on the first cycle imem_req=1 and completes with exactly one imem_ready pulse, possibly in the same cycle (zero-wait).
  - imem_addr equals pc_current whenever imem_req=1. It is stable because the PC is held until accept.
- Arithmetic:
  - next_pc = flush ? branch_target : pc_current + PC_INC, mod 2^ADDR_W (16'hFFFE -> 16'h0000).
  - ifid_pc_plus uses the same wrap.
- accept = (state FETCH or WAIT) & imem_req & imem_ready & ~flush & ~halt_sys & ~stall.
- fetch_stall = ~(accept | flush). The PC advances only on accept or redirect.
- Event priority: rst > flush > halt_sys > stall > accept.
- FSM states:
  - FETCH: imem_req = ~halt_sys.
    - ready & accept -> FETCH (back-to-back, 1 instr/cycle).
    - ready & ~accept (stall or flush) -> FETCH; data dropped, same or target address refetched.
    - req & ~ready & flush -> DISCARD.
    - req & ~ready otherwise -> WAIT.
    - halt_sys -> FETCH, no request.
  - WAIT: imem_req=1 (held even under halt_sys/stall).
    - ready -> FETCH (data loaded only if accept).
    - ~ready & flush -> DISCARD.
  - DISCARD: imem_req=0. PC already redirected.
    - On ready, drop data -> FETCH.
    - A further flush in DISCARD updates next_pc only; stay in DISCARD.
- IF/ID register update:
  - flush: valid 0, instr NOP_INSTR; pc fields are don't-care and hold.
  - else halt_sys or stall: hold all.
  - else accept: instr = imem_data, pc = pc_current, pc_plus = pc_current + PC_INC, valid 1.
  - else: bubble (valid 0, instr NOP_INSTR).
- Latency: instruction visible on ifid_* the cycle after its imem_ready accept. Zero-wait memory gives 1-cycle fetch latency.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e {FETCH, WAIT, DISCARD}
  - NOP_INSTR and PC_INC constants
  - typedef ifid_t struct {instr, pc, pc_plus, valid}
- Sub-module reg_if_id: the IF/ID flop with load/hold/bubble/flush controls.
- FSM, next-PC logic, and stall logic stay in fetch_stage.

Test Plan:
- Zero-wait stream: imem_ready=1 each req, pc_current 0,2,4 -> ifid_pc 0,2,4 on consecutive cycles; fetch_stall never 1; next_pc = pc_current+2.
- 3-cycle memory: ready 3 cycles after req at 0x0010 -> imem_req/imem_addr=0x0010 held, fetch_stall=1 for 2 cycles, ifid_valid=0 bubbles, then ifid_instr=data, ifid_pc=0x0010.
- Flush in WAIT without ready: branch_target=0x0100 -> next_pc=0x0100, fetch_stall=0, state DISCARD, imem_req=0; stale ready dropped (ifid_valid stays 0); next req addr=0x0100.
- Stall with ready: stall=1 as data arrives -> IF/ID holds prior instr, fetch_stall=1; after release same address refetched and loaded once.
- Halt: halt_sys=1 in FETCH -> imem_req=0, IF/ID held; halt in WAIT -> req held until ready, data dropped, then no new req until halt released.
- Wrap and reset: pc_current=0xFFFE accept -> ifid_pc_plus=0x0000, next_pc=0x0000; rst mid-WAIT -> next cycle state FETCH, ifid_valid=0, ifid_instr=0x0000.
